uart_rx_drain_ctrl: RTL

//  Read-side controller for the UART receive FIFO. Arbitrates the FIFO's single read port between a CPU

---
 rtl/uart_rx_drain_if.sv | 23 ++
 rtl/uart_rx_drain_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_drain_if.sv
// Read-side bus between the RX drain controller and its two requesters (CPU single-byte, DMA burst).
interface uart_rx_drain_if #(
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_vld;
  logic [DATA_W-1:0] cpu_data;
  logic              dma_req;
  logic [4:0]        dma_len;
  logic              dma_vld;
  logic [DATA_W-1:0] dma_data;
  logic              dma_done;

  modport master (
    output cpu_req, dma_req, dma_len,
    input  cpu_vld, cpu_data, dma_vld, dma_data, dma_done
  );

  modport slave (
    input  cpu_req, dma_req, dma_len,
    output cpu_vld, cpu_data, dma_vld, dma_data, dma_done
  );
endinterface

// File: rtl/uart_rx_drain_ctrl.sv
// Arbitrates the RX FIFO read port between CPU and DMA, sequences pops and memory latency,
// and raises watermark / character-timeout interrupts.
//
// state  | meaning
// IDLE   | no transfer; grant a pending requester (round-robin when both)
// ISSUE  | pop one byte if FIFO non-empty; DMA with empty FIFO ends its burst here
// WAIT   | covers read latency beyond the first cycle (unused when RD_LAT=1)
// RETURN | mem_rdata valid: hand byte to owner, pulse its vld
module uart_rx_drain_ctrl #(
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 6,
  parameter int RD_LAT    = 1,
  parameter int TO_CYCLES = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_notempty,
  input  logic [LEN_W-1:0]  fifo_level,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fiford,
  uart_rx_drain_if.slave    bus,
  input  logic [LEN_W-1:0]  wm_level,
  input  logic              irq_clr,
  output logic              irq_wm,
  output logic              irq_to
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYCLES);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic [DATA_W-1:0] dma_data_q, dma_data_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              irq_to_q, irq_to_d;
  logic              irq_wm_q, irq_wm_d;
  logic              grant_dma;
  logic              to_hit;

  // Pop is decoded from the live non-empty flag so a pop can never hit an empty FIFO.
  assign fiford       = (state_q == S_ISSUE) && fifo_notempty;
  assign bus.cpu_vld  = (state_q == S_RETURN) && (owner_q == OWN_CPU);
  assign bus.dma_vld  = (state_q == S_RETURN) && (owner_q == OWN_DMA);
  assign bus.dma_done = (bus.dma_vld && (cnt_q == 5'd1)) ||
                        ((state_q == S_ISSUE) && (owner_q == OWN_DMA) && !fifo_notempty);
  // mem_rdata is valid during RETURN, so the byte is presented in the same cycle as vld.
  assign bus.cpu_data = bus.cpu_vld ? mem_rdata : cpu_data_q;
  assign bus.dma_data = bus.dma_vld ? mem_rdata : dma_data_q;
  assign irq_wm       = irq_wm_q;
  assign irq_to       = irq_to_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    cpu_data_d = cpu_data_q;
    dma_data_d = dma_data_q;
    grant_dma  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          grant_dma = bus.dma_req && (!bus.cpu_req || (rr_last_q == OWN_CPU));
          owner_d   = grant_dma;
          rr_last_d = grant_dma;
          if (grant_dma) begin
            cnt_d = (bus.dma_len == 5'd0) ? 5'd1 : bus.dma_len;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fifo_notempty) begin
          wait_d  = WAIT_INIT;
          state_d = (RD_LAT > 1) ? S_WAIT : S_RETURN;
        end else if (owner_q == OWN_DMA) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = S_RETURN;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_RETURN: begin
        if (owner_q == OWN_CPU) begin
          cpu_data_d = mem_rdata;
          state_d    = S_IDLE;
        end else begin
          dma_data_d = mem_rdata;
          if (cnt_q == 5'd1) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q - 5'd1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rx_done || fiford || !fifo_notempty) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    // Fires only on the arrival at the limit, so irq_clr can still drop it while saturated.
    to_hit   = (to_cnt_d == TO_MAX) && (to_cnt_q != TO_MAX);
    irq_to_d = irq_to_q;
    if (to_hit) begin
      irq_to_d = 1'b1;
    end else if (irq_clr || fiford) begin
      irq_to_d = 1'b0;
    end
    irq_wm_d = (wm_level != '0) && (fifo_level >= wm_level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_CPU;
      rr_last_q  <= OWN_DMA;
      cnt_q      <= '0;
      wait_q     <= '0;
      cpu_data_q <= '0;
      dma_data_q <= '0;
      to_cnt_q   <= '0;
      irq_to_q   <= 1'b0;
      irq_wm_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      cpu_data_q <= cpu_data_d;
      dma_data_q <= dma_data_d;
      to_cnt_q   <= to_cnt_d;
      irq_to_q   <= irq_to_d;
      irq_wm_q   <= irq_wm_d;
    end
  end

endmodule
